// File: rtl/ff_bank_readback.sv
// Debug/scan reader for a bank of logic-cell flip-flops: snapshots CQZ_BUS on
// request and streams it out one bit per valid/ready beat, then pulses DONE.
module ff_bank_readback #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             QCK,
  input  logic             QRT,
  input  logic [WIDTH-1:0] CQZ_BUS,
  input  logic             QEN,
  input  logic             REQ,
  output logic             SDO,
  output logic             SDO_VLD,
  input  logic             SDO_RDY,
  output logic             SDO_LAST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_in_shift;
  logic             w_xfer;

  // NOTE: registers update with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge QCK) begin
    if (QRT) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_count  <= w_count_nxt;
    end
  end

  assign w_in_shift = (r_state == S_SHIFT);
  assign w_xfer     = w_in_shift && SDO_RDY;

  // NOTE: every signal is given a hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_count_nxt  = r_count;
    case (r_state)
      S_IDLE: begin
        if (REQ && QEN) begin
          w_shadow_nxt = CQZ_BUS;
          w_count_nxt  = CW'(WIDTH - 1);
          w_state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_xfer) begin
          if (r_count == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            // Zero-filling shift moves the next bit into the output position.
            w_shadow_nxt = LSB_FIRST ? (r_shadow >> 1) : (r_shadow << 1);
            w_count_nxt  = r_count - CW'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign SDO      = w_in_shift && (LSB_FIRST ? r_shadow[0] : r_shadow[WIDTH-1]);
  assign SDO_VLD  = w_in_shift;
  assign SDO_LAST = w_in_shift && (r_count == '0);
  assign BUSY     = w_in_shift;
  assign DONE     = (r_state == S_DONE);

endmodule

// File: tb/tb_ff_bank_readback.sv
// Scoreboard bench for ff_bank_readback: three instances (MSB-first, LSB-first,
// WIDTH=1) share a clock; a negedge monitor pops expected beats on each transfer.
module tb_ff_bank_readback;

  typedef struct {
    int   id;
    logic sdo;
    logic last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       qen;
  logic [2:0] req;
  logic [2:0] rdy;
  logic [7:0] cqz0;
  logic [7:0] cqz1;
  logic [0:0] cqz2;
  logic [2:0] sdo, vld, last, busy, done;

  beat_t exp_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  ff_bank_readback #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .QCK(clk), .QRT(rst), .CQZ_BUS(cqz0), .QEN(qen), .REQ(req[0]),
    .SDO(sdo[0]), .SDO_VLD(vld[0]), .SDO_RDY(rdy[0]), .SDO_LAST(last[0]),
    .BUSY(busy[0]), .DONE(done[0])
  );

  ff_bank_readback #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .QCK(clk), .QRT(rst), .CQZ_BUS(cqz1), .QEN(qen), .REQ(req[1]),
    .SDO(sdo[1]), .SDO_VLD(vld[1]), .SDO_RDY(rdy[1]), .SDO_LAST(last[1]),
    .BUSY(busy[1]), .DONE(done[1])
  );

  ff_bank_readback #(.WIDTH(1), .LSB_FIRST(1'b0)) u_one (
    .QCK(clk), .QRT(rst), .CQZ_BUS(cqz2), .QEN(qen), .REQ(req[2]),
    .SDO(sdo[2]), .SDO_VLD(vld[2]), .SDO_RDY(rdy[2]), .SDO_LAST(last[2]),
    .BUSY(busy[2]), .DONE(done[2])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beats are listed first-out leftmost in the low n bits of 'bits'.
  task automatic push_seq(input int id, input int n, input logic [7:0] bits, input int total);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.id   = id;
      b.sdo  = bits[n-1-k];
      b.last = (k == total - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: transfer checks, stall stability and DONE timing per instance.
  logic [2:0] exp_done = '0;
  logic [2:0] held_v   = '0;
  logic [2:0] held_sdo, held_last;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("done_timing[%0d]", i), done[i], exp_done[i]);
      if (held_v[i])
        check($sformatf("stall_hold[%0d]", i), {vld[i], sdo[i], last[i]},
              {1'b1, held_sdo[i], held_last[i]});
      exp_done[i] = 1'b0;
      held_v[i]   = 1'b0;
      if (!rst && vld[i]) begin
        if (rdy[i]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_beat[%0d]", i), 1'b1, 1'b0);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check($sformatf("beat_inst[%0d]", i), 64'(i), 64'(e.id));
            check($sformatf("beat_sdo_last[%0d]", i), {sdo[i], last[i]}, {e.sdo, e.last});
            exp_done[i] = e.last;
          end
        end else begin
          held_v[i]    = 1'b1;
          held_sdo[i]  = sdo[i];
          held_last[i] = last[i];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat, stall, shift_cycles;
    rst = 1'b1; qen = 1'b1; req = 3'b111; rdy = 3'b111;
    cqz0 = 8'h00; cqz1 = 8'h00; cqz2 = 1'b0;

    // Reset with REQ/QEN asserted: everything stays quiet.
    tick(); tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outs[%0d]", i), {sdo[i], vld[i], last[i], busy[i], done[i]}, 5'b0);

    // Release with REQ held on the MSB-first instance: basic 8'hA5 readback.
    rst = 1'b0; req = 3'b001; cqz0 = 8'hA5;
    push_seq(0, 8, 8'b10100101, 8);
    tick();
    check("first_valid_latency", {vld[0], busy[0]}, 2'b11);
    req = 3'b000;
    repeat (8) tick();
    check("basic_done_cycle", {done[0], busy[0], vld[0], last[0], sdo[0]}, 5'b10000);
    tick();
    check("basic_back_idle", {done[0], busy[0]}, 2'b00);

    // Backpressure: beats 2 and 5 stalled for 3 cycles each.
    cqz0 = 8'h3C;
    push_seq(0, 8, 8'b00111100, 8);
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    beat = 1; stall = 0; shift_cycles = 0;
    for (int c = 0; c < 40 && busy[0]; c++) begin
      if ((beat == 2 || beat == 5) && stall < 3) begin
        rdy[0] = 1'b0;
        stall++;
      end else begin
        rdy[0] = 1'b1;
      end
      shift_cycles++;
      tick();
      if (rdy[0]) begin
        beat++;
        stall = 0;
      end
    end
    rdy[0] = 1'b1;
    check("bp_shift_cycles", 64'(shift_cycles), 64'd14);
    tick();

    // Snapshot and order on the LSB-first instance; REQ held through SHIFT and DONE.
    cqz1 = 8'h81;
    push_seq(1, 8, 8'b10000001, 8);
    req[1] = 1'b1;
    tick();
    cqz1 = 8'h00;
    repeat (8) tick();
    check("lsb_done_cycle", done[1], 1'b1);
    tick();
    req[1] = 1'b0;
    check("lsb_no_restart", {busy[1], vld[1]}, 2'b00);
    tick();
    check("lsb_still_idle", busy[1], 1'b0);

    cqz1 = 8'h0D;
    push_seq(1, 8, 8'b10110000, 8);
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    cqz1 = 8'hFF;
    repeat (10) tick();
    check("lsb2_idle", busy[1], 1'b0);

    // QEN gating: REQ ignored for 5 cycles.
    qen = 1'b0; req[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("gated_%0d", c), {busy[0], vld[0]}, 2'b00);
    end
    qen = 1'b1; req[0] = 1'b0;

    // Abort after 3 beats of 8'h5A; no DONE afterwards, then a full fresh stream.
    cqz0 = 8'h5A;
    push_seq(0, 3, 8'b00000010, 8);
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("abort_outs", {sdo[0], vld[0], last[0], busy[0], done[0]}, 5'b0);
    rst = 1'b0;
    tick();
    check("abort_no_done", {done[0], busy[0]}, 2'b00);

    cqz0 = 8'hC3;
    push_seq(0, 8, 8'b11000011, 8);
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    for (int c = 0; c < 20 && busy[0]; c++) tick();
    check("fresh_stream_ended", busy[0], 1'b0);
    tick();

    // WIDTH=1 instance: single beat, LAST set, DONE next cycle.
    cqz2 = 1'b1;
    push_seq(2, 1, 8'b00000001, 1);
    req[2] = 1'b1;
    tick();
    req[2] = 1'b0;
    check("w1_beat", {sdo[2], vld[2], last[2]}, 3'b111);
    tick();
    check("w1_done", {done[2], busy[2]}, 2'b10);
    tick(); tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ff_bank_readback.md
Name: ff_bank_readback

Overview:
- Reads back the state of a bank of logic-cell flip-flops and sends it out serially.
- Takes a single-cycle snapshot of a parallel vector of FF outputs on request, then shifts it out one bit per beat over a valid/ready handshake.
- Sits beside the FF bank as its debug/scan reader. Used by configuration-readback and test logic to observe CQZ state without disturbing the FFs.

Parameters:
- WIDTH, 8, number of FF bits in the bank (legal range 1..64).
- LSB_FIRST, 0, bit order: 0 = bit WIDTH-1 first, 1 = bit 0 first.

Ports:
- QCK  input  1  clock; all state changes on the rising edge.
- QRT  input  1  reset; synchronous, active-high.
- CQZ_BUS  input  WIDTH  parallel FF outputs to be read.
- QEN  input  1  capture enable; a request is accepted only when QEN=1.
- REQ  input  1  start-readback request; level-sampled.
- SDO  output  1  serial data bit.
- SDO_VLD  output  1  SDO holds a valid beat.
- SDO_RDY  input  1  consumer accepts the beat.
- SDO_LAST  output  1  current beat is the final bit.
- BUSY  output  1  a readback is in progress.
- DONE  output  1  one-cycle pulse after the last beat transfers.

Behaviour:
- States: IDLE, SHIFT, DONE. Registers: shadow[WIDTH], count, state.
- Reset (QRT=1 at edge):
  - state=IDLE; shadow=0; count=0.
  - SDO=0, SDO_VLD=0, SDO_LAST=0, BUSY=0, DONE=0.
  - QRT wins over every other input in the same cycle.
- IDLE:
  - REQ=1 and QEN=1 at an edge:
    - shadow<=CQZ_BUS, count<=WIDTH-1, state<=SHIFT.
    - SDO_VLD and BUSY are 1 from the next cycle, so latency from REQ sample to first valid beat is 1 cycle.
  - REQ with QEN=0: ignored, stay IDLE.
- SHIFT:
  - SDO_VLD=1, BUSY=1.
  - SDO = shadow[WIDTH-1] when LSB_FIRST=0, shadow[0] when LSB_FIRST=1.
  - SDO_LAST = (count==0).
  - Transfer occurs at an edge with SDO_VLD=1 and SDO_RDY=1:
    - count!=0: shift shadow toward the output end, zero-fill, count<=count-1.
    - count==0: state<=DONE.
  - SDO_RDY=0: SDO, SDO_LAST, shadow and count hold. SDO_VLD never drops before its transfer.
  - REQ and QEN are ignored while in SHIFT. There is no queueing and no restart.
  - CQZ_BUS changes after capture do not affect the stream.
- DONE:
  - Lasts exactly one cycle: DONE=1, BUSY=0, SDO_VLD=0, SDO_LAST=0, SDO=0; state<=IDLE.
  - REQ in the DONE cycle is ignored. A new readback needs REQ sampled in IDLE, so minimum spacing between starts is WIDTH+2 cycles with SDO_RDY held at 1.
- SDO, SDO_VLD, SDO_LAST, BUSY and DONE are pure functions of the registered state; there is no combinational path from any input.
- WIDTH=1: the single beat has SDO_LAST=1; DONE follows the cycle after its transfer.
- Reset mid-SHIFT: abort; outputs take reset values after the edge; no DONE pulse is generated.
- count width is clog2(WIDTH), minimum 1 bit.

Test Plan:
- Reset check: hold QRT=1 for 2 cycles with REQ=1, QEN=1 -> all outputs 0 and state IDLE; after release, REQ sampled -> SDO_VLD=1 on the next cycle.
- Basic readback: CQZ_BUS=8'hA5, LSB_FIRST=0, SDO_RDY=1, REQ for 1 cycle ->
  - SDO sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles;
  - SDO_LAST=1 on the 8th beat only;
  - DONE=1 on the following cycle, then IDLE.
- Backpressure: CQZ_BUS=8'h3C, SDO_RDY=0 for beats 2 and 5 for 3 cycles each ->
  - SDO/SDO_LAST stable and SDO_VLD=1 during stalls;
  - stream 0,0,1,1,1,1,0,0 delivered intact;
  - total SHIFT duration 14 cycles.
- Snapshot and order: LSB_FIRST=1, CQZ_BUS=8'h81 at capture, then CQZ_BUS changed to 8'h00 ->
  - stream 1,0,0,0,0,0,0,1;
  - REQ pulses during SHIFT and in the DONE cycle have no effect.
- Gating and abort: REQ=1 with QEN=0 for 5 cycles -> no activity; start a readback, assert QRT after 3 beats -> outputs 0 on the next cycle, no DONE pulse, and a new REQ starts a fresh full 8-beat stream.
- WIDTH=1 instance: CQZ_BUS=1 -> a single beat with SDO=1 and SDO_LAST=1, DONE on the next cycle.
